uart_rx_oversampler: RTL

- Serial UART receive stage directly downstream of the clock divider.
- Consumes the divider's oversample tick as a one-clk enable pulse, not as a clock. Runs entirely in the clk domain.
- Synchronises the raw rx line, detects and validates start bits, samples data mid-bit and checks the stop bit.
- Presents each received byte on a valid/ready handshake toward the consuming logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_oversampler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, default frame
// geometry, counter widths and the idle level of the serial line.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    localparam int TICK_CNT_W = $clog2(DEFAULT_OVERSAMPLE);
    localparam int BIT_IDX_W  = $clog2(DEFAULT_DATA_BITS + 1);

    localparam logic RX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so idle-high lines do not present a false edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic areset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receiver driven by an oversample enable tick. Validates the start bit
// at its midpoint, samples each data bit mid-bit (LSB first), checks the stop
// bit and hands the word to the consumer over a valid/ready handshake.
module uart_rx_oversampler
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [TCW-1:0] HALF_TICK = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

    logic                 w_rxSync;

    rxState_t             r_state;
    logic [TCW-1:0]       r_tickCnt;
    logic [BCW-1:0]       r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_doutValid;
    logic                 r_framingErr;
    logic                 r_overrunErr;

    rxState_t             w_stateNext;
    logic [TCW-1:0]       w_tickNext;
    logic [BCW-1:0]       w_bitNext;
    logic [DATA_BITS-1:0] w_shiftNext;
    logic [DATA_BITS-1:0] w_doutNext;
    logic                 w_validNext;
    logic                 w_framingNext;
    logic                 w_overrunNext;

    sync_2ff #(
        .RESET_VAL (RX_IDLE_LEVEL)
    ) u_rxSync (
        .clk      (clk),
        .areset_n (areset_n),
        .i_d      (rx),
        .o_q      (w_rxSync)
    );

    // Register the FSM, counters, output word and one-cycle error pulses.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state      <= IDLE;
            r_tickCnt    <= '0;
            r_bitIdx     <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_doutValid  <= 1'b0;
            r_framingErr <= 1'b0;
            r_overrunErr <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_tickCnt    <= w_tickNext;
            r_bitIdx     <= w_bitNext;
            r_shift      <= w_shiftNext;
            r_dout       <= w_doutNext;
            r_doutValid  <= w_validNext;
            r_framingErr <= w_framingNext;
            r_overrunErr <= w_overrunNext;
        end
    end

    // Next-state logic: everything advances only on sample_tick, except the
    // handshake clear and the error pulses, which must be exactly one clk.
    // A word load is evaluated after the acceptance clear so that a load in
    // the same cycle as an acceptance leaves dout_valid high.
    always_comb begin
        w_stateNext   = r_state;
        w_tickNext    = r_tickCnt;
        w_bitNext     = r_bitIdx;
        w_shiftNext   = r_shift;
        w_doutNext    = r_dout;
        w_validNext   = r_doutValid;
        w_framingNext = 1'b0;
        w_overrunNext = 1'b0;

        if (r_doutValid && dout_ready) begin
            w_validNext = 1'b0;
        end

        if (sample_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (w_rxSync != RX_IDLE_LEVEL) begin
                        w_stateNext = START;
                        w_tickNext  = '0;
                    end
                end
                START: begin
                    if (r_tickCnt == HALF_TICK) begin
                        if (w_rxSync != RX_IDLE_LEVEL) begin
                            w_stateNext = DATA;
                            w_tickNext  = '0;
                            w_bitNext   = '0;
                        end else begin
                            w_stateNext = IDLE;
                            w_tickNext  = '0;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TCW'(1);
                    end
                end
                DATA: begin
                    if (r_tickCnt == LAST_TICK) begin
                        w_shiftNext = {w_rxSync, r_shift[DATA_BITS-1:1]};
                        w_tickNext  = '0;
                        w_bitNext   = r_bitIdx + BCW'(1);
                        if (r_bitIdx == LAST_BIT) begin
                            w_stateNext = STOP;
                        end
                    end else begin
                        w_tickNext = r_tickCnt + TCW'(1);
                    end
                end
                STOP: begin
                    if (r_tickCnt == LAST_TICK) begin
                        if (w_rxSync == RX_IDLE_LEVEL) begin
                            w_doutNext    = r_shift;
                            w_validNext   = 1'b1;
                            w_overrunNext = r_doutValid && !dout_ready;
                        end else begin
                            w_framingNext = 1'b1;
                        end
                        w_stateNext = IDLE;
                        w_tickNext  = '0;
                    end else begin
                        w_tickNext = r_tickCnt + TCW'(1);
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_tickNext  = '0;
                end
            endcase
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_doutValid;
    assign framing_err = r_framingErr;
    assign overrun_err = r_overrunErr;
    assign busy        = (r_state != IDLE);

endmodule
